block_ram_dp: RTL and testbench

//  Next-generation on-chip RAM: simple dual-port synchronous RAM.
//  - Port A: read/write with per-byte write enables.
//  - Port B: independent read-only port.
//  - Selectable read-during-write mode and optional output pipeline register.
//  - Optional hardware clear sweep after reset.
//  - Used as the shared buffer between datapath stages that write and read concurrently.

---
 rtl/block_ram_dp_pkg.sv | 14 +
 rtl/block_ram_out_stage.sv | 34 +++
 rtl/block_ram_dp.sv | 149 ++++++++++++++
 tb/tb_block_ram_dp.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/block_ram_dp_pkg.sv
// Shared constants for block_ram_dp: read-during-write mode codes and the
// clear-sweep state encoding.
package block_ram_dp_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;
  localparam int RDW_NO_CHANGE   = 2;

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_SWEEP = 1'b1
  } clr_state_t;

endpackage

// File: rtl/block_ram_out_stage.sv
// Optional output register for one RAM read port; a plain wire-through when
// OUT_REG is 0. The data register only loads on a valid beat, so it holds.
module block_ram_out_stage #(
  parameter int W       = 32,
  parameter int OUT_REG = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         vin,
  output logic [W-1:0] dout,
  output logic         vout
);

  if (OUT_REG != 0) begin : g_reg
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
      if (rst) begin
        dout <= '0;
        vout <= 1'b0;
      end else begin
        vout <= vin;
        if (vin) dout <= din;
      end
    end
  end else begin : g_bypass
    logic unused_ok;
    assign unused_ok = ^{clk, rst};
    assign dout      = din;
    assign vout      = vin;
  end

endmodule

// File: rtl/block_ram_dp.sv
// Simple dual-port synchronous RAM: port A read/write with byte enables,
// port B read-only, selectable read-during-write and optional clear sweep.
module block_ram_dp
  import block_ram_dp_pkg::*;
#(
  parameter int                    RAM_WIDTH      = 32,
  parameter int                    RAM_DEPTH      = 256,
  parameter string                 INIT_FILE      = "",
  parameter int                    RDW_MODE       = RDW_READ_FIRST,
  parameter int                    OUT_REG        = 0,
  parameter int                    CLEAR_ON_RESET = 0,
  parameter logic [RAM_WIDTH-1:0]  CLEAR_VALUE    = '0,
  localparam int                   AW             = $clog2(RAM_DEPTH),
  localparam int                   NB             = RAM_WIDTH / 8
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 busy,
  input  logic                 a_en,
  input  logic [NB-1:0]        a_we,
  input  logic [AW-1:0]        a_addr,
  input  logic [RAM_WIDTH-1:0] a_din,
  output logic [RAM_WIDTH-1:0] a_dout,
  output logic                 a_valid,
  input  logic                 b_en,
  input  logic [AW-1:0]        b_addr,
  output logic [RAM_WIDTH-1:0] b_dout,
  output logic                 b_valid
);

  localparam bit A_RD_ON_WR = (RDW_MODE != RDW_NO_CHANGE);

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

  logic          clr_we;
  logic [AW-1:0] clr_addr;

  if (CLEAR_ON_RESET != 0) begin : g_clear
    clr_state_t    state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk) begin
      if (rst) begin
        state <= CLR_SWEEP;
        cnt   <= '0;
      end else begin
        state <= state_nxt;
        cnt   <= cnt_nxt;
      end
    end

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      clr_we    = 1'b0;
      if (state == CLR_SWEEP && !rst) begin
        clr_we  = 1'b1;
        cnt_nxt = cnt + 1'b1;
        if (cnt == AW'(RAM_DEPTH - 1)) begin
          state_nxt = CLR_IDLE;
          cnt_nxt   = '0;
        end
      end
    end

    assign busy     = (state == CLR_SWEEP);
    assign clr_addr = cnt;
  end else begin : g_no_clear
    assign busy     = 1'b0;
    assign clr_we   = 1'b0;
    assign clr_addr = '0;
  end

  logic a_in_range, b_in_range, a_rd, a_wr, b_rd;
  assign a_in_range = {1'b0, a_addr} < (AW + 1)'(RAM_DEPTH);
  assign b_in_range = {1'b0, b_addr} < (AW + 1)'(RAM_DEPTH);
  assign a_rd       = a_en && !busy && (a_we == '0);
  assign a_wr       = a_en && !busy && (a_we != '0);
  assign b_rd       = b_en && !busy;

  // Single byte-enabled write port shared by the clear sweep and port A.
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [NB-1:0]        wr_be;
  logic [RAM_WIDTH-1:0] wr_data;
  assign wr_en   = clr_we || (a_wr && a_in_range);
  assign wr_addr = clr_we ? clr_addr : a_addr;
  assign wr_be   = clr_we ? {NB{1'b1}} : a_we;
  assign wr_data = clr_we ? CLEAR_VALUE : a_din;

  function automatic logic [RAM_WIDTH-1:0] merge_bytes(
    input logic [RAM_WIDTH-1:0] old_w,
    input logic [RAM_WIDTH-1:0] new_w,
    input logic [NB-1:0]        be
  );
    logic [RAM_WIDTH-1:0] r;
    r = old_w;
    for (int i = 0; i < NB; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  // NOTE: the array has no reset; a reset term would stop it mapping onto
  // block RAM, and rst leaves contents untouched anyway.
  always_ff @(posedge clk) begin
    if (wr_en)
      for (int i = 0; i < NB; i++)
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
  end

  logic [RAM_WIDTH-1:0] a_q, b_q;
  logic                 a_v, b_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      a_v <= 1'b0;
    end else begin
      a_v <= 1'b0;
      if (a_rd || (a_wr && A_RD_ON_WR)) begin
        a_v <= 1'b1;
        if (!a_in_range)                          a_q <= '0;
        else if (a_wr && RDW_MODE == RDW_WRITE_FIRST) a_q <= merge_bytes(mem[a_addr], a_din, a_we);
        else                                      a_q <= mem[a_addr];
      end
    end
  end

  // Port B reads the pre-write word on an address collision with port A.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_q <= '0;
      b_v <= 1'b0;
    end else begin
      b_v <= b_rd;
      if (b_rd) b_q <= b_in_range ? mem[b_addr] : '0;
    end
  end

  block_ram_out_stage #(.W(RAM_WIDTH), .OUT_REG(OUT_REG)) u_out_a (
    .clk(clk), .rst(rst), .din(a_q), .vin(a_v), .dout(a_dout), .vout(a_valid)
  );

  block_ram_out_stage #(.W(RAM_WIDTH), .OUT_REG(OUT_REG)) u_out_b (
    .clk(clk), .rst(rst), .din(b_q), .vin(b_v), .dout(b_dout), .vout(b_valid)
  );

endmodule

// File: tb/tb_block_ram_dp.sv
// Directed bench for block_ram_dp: three RDW variants (depth 200) plus a
// clear-sweep / output-register variant (depth 16) driven from shared stimulus.
module tb_block_ram_dp;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_en, b_en;
  logic [3:0]  a_we;
  logic [7:0]  a_addr, b_addr;
  logic [31:0] a_din;

  logic        rf_busy, wf_busy, nc_busy, cl_busy;
  logic [31:0] rf_a_dout, wf_a_dout, nc_a_dout, cl_a_dout;
  logic [31:0] rf_b_dout, wf_b_dout, nc_b_dout, cl_b_dout;
  logic        rf_a_valid, wf_a_valid, nc_a_valid, cl_a_valid;
  logic        rf_b_valid, wf_b_valid, nc_b_valid, cl_b_valid;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  block_ram_dp #(.RAM_DEPTH(200), .RDW_MODE(0)) dut_rf (
    .clk(clk), .rst(rst), .busy(rf_busy),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
    .a_dout(rf_a_dout), .a_valid(rf_a_valid),
    .b_en(b_en), .b_addr(b_addr), .b_dout(rf_b_dout), .b_valid(rf_b_valid)
  );

  block_ram_dp #(.RAM_DEPTH(200), .RDW_MODE(1)) dut_wf (
    .clk(clk), .rst(rst), .busy(wf_busy),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
    .a_dout(wf_a_dout), .a_valid(wf_a_valid),
    .b_en(b_en), .b_addr(b_addr), .b_dout(wf_b_dout), .b_valid(wf_b_valid)
  );

  block_ram_dp #(.RAM_DEPTH(200), .RDW_MODE(2)) dut_nc (
    .clk(clk), .rst(rst), .busy(nc_busy),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
    .a_dout(nc_a_dout), .a_valid(nc_a_valid),
    .b_en(b_en), .b_addr(b_addr), .b_dout(nc_b_dout), .b_valid(nc_b_valid)
  );

  block_ram_dp #(.RAM_DEPTH(16), .OUT_REG(1), .CLEAR_ON_RESET(1),
                 .CLEAR_VALUE(32'h0000_DEAD)) dut_cl (
    .clk(clk), .rst(rst), .busy(cl_busy),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr[3:0]), .a_din(a_din),
    .a_dout(cl_a_dout), .a_valid(cl_a_valid),
    .b_en(b_en), .b_addr(b_addr[3:0]), .b_dout(cl_b_dout), .b_valid(cl_b_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_en = 1'b0;
    a_we = 4'h0;
    b_en = 1'b0;
  endtask

  task automatic wait_sweep(input string tag);
    n = 0;
    while (cl_busy && n < 40) begin
      step();
      n++;
      check({tag, "_a_valid_busy"}, cl_a_valid, 0);
      check({tag, "_b_valid_busy"}, cl_b_valid, 0);
    end
    check({tag, "_busy_cycles"}, n, 16);
  endtask

  task automatic readback_dead(input string tag);
    for (int i = 0; i <= 16; i++) begin
      b_en   = (i < 16);
      b_addr = 8'(i);
      step();
      if (i >= 1) begin
        check({tag, "_b_valid"}, cl_b_valid, 1);
        check({tag, "_b_dout"}, cl_b_dout, 32'h0000_DEAD);
      end
    end
    idle();
  endtask

  initial begin
    rst = 1'b1; idle(); a_addr = '0; a_din = '0; b_addr = '0;
    step(); step();
    check("rst_rf_a_dout", rf_a_dout, 0);
    check("rst_rf_a_valid", rf_a_valid, 0);
    check("rst_rf_b_valid", rf_b_valid, 0);
    check("rst_rf_busy", rf_busy, 0);
    check("rst_cl_busy", cl_busy, 1);
    check("rst_cl_b_dout", cl_b_dout, 0);

    // Clear sweep with requests pending the whole time.
    rst = 1'b0; a_en = 1'b1; b_en = 1'b1;
    wait_sweep("sweep1");
    idle();
    step();
    check("sweep1_post_a_valid", cl_a_valid, 0);
    check("sweep1_post_b_valid", cl_b_valid, 0);
    readback_dead("sweep1_rd");

    // Byte enables.
    a_en = 1'b1; a_we = 4'hF; a_addr = 8'd5; a_din = 32'hAABB_CCDD; step();
    a_we = 4'b0101; a_din = 32'h1122_3344; step();
    a_we = 4'h0; step();
    check("be_rf_a_valid", rf_a_valid, 1);
    check("be_rf_a_dout", rf_a_dout, 32'hAA22_CC44);
    idle(); step();
    check("be_rf_a_valid_pulse", rf_a_valid, 0);
    check("be_cl_a_valid_lat2", cl_a_valid, 1);
    check("be_cl_a_dout_lat2", cl_a_dout, 32'hAA22_CC44);

    // Read-during-write modes on port A.
    a_en = 1'b1; a_we = 4'hF; a_addr = 8'd3; a_din = 32'h1; step();
    a_din = 32'h2; step();
    check("rdw_rf_a_dout", rf_a_dout, 32'h1);
    check("rdw_rf_a_valid", rf_a_valid, 1);
    check("rdw_wf_a_dout", wf_a_dout, 32'h2);
    check("rdw_wf_a_valid", wf_a_valid, 1);
    check("rdw_nc_a_valid", nc_a_valid, 0);
    check("rdw_nc_a_dout_hold", nc_a_dout, 32'hAA22_CC44);
    a_we = 4'b0010; a_din = 32'h0000_AB00; step();
    check("rdw_wf_merge", wf_a_dout, 32'h0000_AB02);
    check("rdw_rf_old", rf_a_dout, 32'h2);
    a_we = 4'h0; step();
    check("rdw_rf_visible", rf_a_dout, 32'h0000_AB02);
    check("rdw_nc_read_valid", nc_a_valid, 1);
    idle();

    // Port A write vs port B read, same address.
    a_en = 1'b1; a_we = 4'hF; a_addr = 8'd7; a_din = 32'h11; step();
    a_din = 32'h55; b_en = 1'b1; b_addr = 8'd7; step();
    check("col_rf_b_dout_old", rf_b_dout, 32'h11);
    check("col_rf_b_valid", rf_b_valid, 1);
    check("col_wf_b_dout_old", wf_b_dout, 32'h11);
    a_en = 1'b0; step();
    check("col_rf_b_dout_new", rf_b_dout, 32'h55);
    b_en = 1'b0; step();
    check("col_rf_b_valid_low", rf_b_valid, 0);
    check("col_rf_b_dout_hold", rf_b_dout, 32'h55);

    // Address range edges on a depth-200 array.
    a_en = 1'b1; a_we = 4'hF; a_addr = 8'd250; a_din = 32'h77; step();
    a_we = 4'h0; b_en = 1'b1; b_addr = 8'd250; step();
    check("oor_rf_a_dout", rf_a_dout, 0);
    check("oor_rf_a_valid", rf_a_valid, 1);
    check("oor_rf_b_dout", rf_b_dout, 0);
    check("oor_rf_b_valid", rf_b_valid, 1);
    b_en = 1'b0; a_we = 4'hF; a_addr = 8'd199; a_din = 32'h1234; step();
    a_we = 4'h0; step();
    check("top_rf_a_dout", rf_a_dout, 32'h1234);
    idle();

    // Fill the small array with distinct words, then stream port B.
    for (int i = 0; i < 16; i++) begin
      a_en = 1'b1; a_we = 4'hF; a_addr = 8'(i); a_din = 32'h100 + 32'(i);
      step();
    end
    idle(); step();
    for (int i = 0; i <= 9; i++) begin
      b_en   = (i < 8);
      b_addr = 8'(i);
      step();
      if (i >= 1 && i <= 8) begin
        check("str_cl_b_valid", cl_b_valid, 1);
        check("str_cl_b_dout", cl_b_dout, 32'h100 + 32'(i - 1));
      end else begin
        check("str_cl_b_valid_off", cl_b_valid, 0);
      end
    end
    idle();

    // Reset in the middle of a sweep restarts it from address 0.
    rst = 1'b1; step();
    rst = 1'b0;
    for (int i = 0; i < 9; i++) step();
    check("mid_busy_before", cl_busy, 1);
    rst = 1'b1; step(); step();
    check("mid_busy_in_rst", cl_busy, 1);
    rst = 1'b0;
    wait_sweep("sweep2");
    readback_dead("sweep2_rd");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
